// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types and requester ids for the data memory arbiter
package dmem_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   localparam logic REQ_CORE = 1'b0;
   localparam logic REQ_DBG  = 1'b1;

endpackage

// File: rtl/rr_arbiter2.sv
// rtl/rr_arbiter2.sv - two-way round-robin grant, one-hot, combinational
module rr_arbiter2
   import dmem_pkg::*;
(
   input  logic [1:0] valid,
   input  logic       last,
   output logic [1:0] grant
);

   always_comb begin
      grant = 2'b00;
      case (valid)
         2'b01:   grant = 2'b01;
         2'b10:   grant = 2'b10;
         // Contention: the port that did not win last time goes first.
         2'b11:   grant = (last == REQ_DBG) ? 2'b01 : 2'b10;
         default: grant = 2'b00;
      endcase
   end

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - shares a single-port data memory between core and debug requesters
module dmem_arbiter
   import dmem_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int DEPTH = 64
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            req0_valid_i,
   output logic            req0_ready_o,
   input  logic            req0_we_i,
   input  logic [XLEN-1:0] req0_addr_i,
   input  logic [XLEN-1:0] req0_wdata_i,
   output logic            req0_rvalid_o,
   output logic [XLEN-1:0] req0_rdata_o,
   input  logic            req1_valid_i,
   output logic            req1_ready_o,
   input  logic            req1_we_i,
   input  logic [XLEN-1:0] req1_addr_i,
   input  logic [XLEN-1:0] req1_wdata_i,
   output logic            req1_rvalid_o,
   output logic [XLEN-1:0] req1_rdata_o,
   output logic [XLEN-1:0] mem_addr_o,
   output logic            mem_we_o,
   output logic [XLEN-1:0] mem_wdata_o,
   input  logic [XLEN-1:0] mem_rdata_i
);

   state_t          state_q;
   logic            last_q;
   logic            owner_q;
   logic            we_q;
   logic [XLEN-1:0] addr_q;
   logic [XLEN-1:0] wdata_q;
   logic [XLEN-1:0] rdata_q;

   logic [1:0] grant;
   logic       winner;
   logic       handshake;
   logic       in_range;

   rr_arbiter2 u_arb (
      .valid ({req1_valid_i, req0_valid_i}),
      .last  (last_q),
      .grant (grant)
   );

   assign winner    = grant[1];
   assign handshake = (state_q == IDLE) && (grant != 2'b00);
   assign in_range  = addr_q < XLEN'(DEPTH);

   // Ready is gated by reset so nothing looks accepted while the block is held.
   assign req0_ready_o = rst_ni && (state_q == IDLE) && grant[0];
   assign req1_ready_o = rst_ni && (state_q == IDLE) && grant[1];

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         last_q  <= 1'b1;
         owner_q <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (handshake) begin
                  addr_q  <= winner ? req1_addr_i  : req0_addr_i;
                  wdata_q <= winner ? req1_wdata_i : req0_wdata_i;
                  we_q    <= winner ? req1_we_i    : req0_we_i;
                  owner_q <= winner;
                  last_q  <= winner;
                  state_q <= ACCESS;
               end
            end
            ACCESS: begin
               rdata_q <= (!we_q && in_range) ? mem_rdata_i : '0;
               state_q <= RESP;
            end
            RESP:    state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   // Address and data hold their latched values; only the write strobe is qualified.
   assign mem_addr_o  = addr_q;
   assign mem_wdata_o = wdata_q;
   assign mem_we_o    = (state_q == ACCESS) && we_q && in_range;

   assign req0_rvalid_o = (state_q == RESP) && (owner_q == REQ_CORE);
   assign req1_rvalid_o = (state_q == RESP) && (owner_q == REQ_DBG);
   assign req0_rdata_o  = req0_rvalid_o ? rdata_q : '0;
   assign req1_rdata_o  = req1_rvalid_o ? rdata_q : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - scoreboard bench for dmem_arbiter with a behavioural memory
module tb_dmem_arbiter;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req0_valid = 1'b0, req0_we = 1'b0;
   logic [31:0] req0_addr = '0, req0_wdata = '0;
   logic        req1_valid = 1'b0, req1_we = 1'b0;
   logic [31:0] req1_addr = '0, req1_wdata = '0;
   logic        req0_ready, req1_ready, req0_rvalid, req1_rvalid;
   logic [31:0] req0_rdata, req1_rdata;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic        mem_we;

   int checks = 0;
   int errors = 0;
   int exp_port_q[$];
   logic [31:0] exp_data_q[$];
   int grant_log[$];

   logic [31:0] mem [64];
   bit          mem_inited = 1'b0;

   always #5 clk = ~clk;

   dmem_arbiter #(.XLEN(32), .DEPTH(64)) dut (
      .clk_i         (clk),
      .rst_ni        (rst_n),
      .req0_valid_i  (req0_valid),
      .req0_ready_o  (req0_ready),
      .req0_we_i     (req0_we),
      .req0_addr_i   (req0_addr),
      .req0_wdata_i  (req0_wdata),
      .req0_rvalid_o (req0_rvalid),
      .req0_rdata_o  (req0_rdata),
      .req1_valid_i  (req1_valid),
      .req1_ready_o  (req1_ready),
      .req1_we_i     (req1_we),
      .req1_addr_i   (req1_addr),
      .req1_wdata_i  (req1_wdata),
      .req1_rvalid_o (req1_rvalid),
      .req1_rdata_o  (req1_rdata),
      .mem_addr_o    (mem_addr),
      .mem_we_o      (mem_we),
      .mem_wdata_o   (mem_wdata),
      .mem_rdata_i   (mem_rdata)
   );

   // Out-of-range reads see garbage so the arbiter's zeroing is observable.
   assign mem_rdata = (mem_addr < 32'd64) ? mem[mem_addr[5:0]] : 32'hBAD0_BAD0;

   always @(posedge clk) begin
      if (!mem_inited) begin
         for (int i = 0; i < 64; i++) mem[i] <= '0;
         mem_inited <= 1'b1;
      end else if (mem_we && mem_addr < 32'd64) begin
         mem[mem_addr[5:0]] <= mem_wdata;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic set_req(input int p, input logic v, input logic we,
                          input logic [31:0] a, input logic [31:0] d);
      if (p == 0) begin
         req0_valid = v; req0_we = we; req0_addr = a; req0_wdata = d;
      end else begin
         req1_valid = v; req1_we = we; req1_addr = a; req1_wdata = d;
      end
   endtask

   // Holds valid until accepted, then scrambles the fields; returns #1 into the ACCESS cycle.
   task automatic req(input int p, input logic we, input logic [31:0] a,
                      input logic [31:0] d, input logic [31:0] exp);
      bit done = 1'b0;
      @(negedge clk);
      set_req(p, 1'b1, we, a, d);
      for (int i = 0; i < 40 && !done; i++) begin
         #1;
         if ((p == 0) ? req0_ready : req1_ready) begin
            @(posedge clk);
            exp_port_q.push_back(p);
            exp_data_q.push_back(exp);
            grant_log.push_back(p);
            done = 1'b1;
            #1;
            set_req(p, 1'b0, ~we, a ^ 32'hFFFF_0000, ~d);
         end else begin
            @(negedge clk);
         end
      end
      if (!done) begin
         checks++;
         errors++;
         $display("FAIL req_timeout: port %0d got no ready expected ready within 40 cycles", p);
         set_req(p, 1'b0, we, a, d);
      end
   endtask

   task automatic drain();
      int n = 0;
      while (exp_port_q.size() != 0 && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("drain_queue_empty", 32'(exp_port_q.size()), 32'd0);
      @(negedge clk);
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         if (req0_rvalid && req1_rvalid) begin
            checks++;
            errors++;
            $display("FAIL rvalid_overlap: got both rvalid expected one");
         end else if (req0_rvalid || req1_rvalid) begin
            if (exp_port_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_rvalid: got rvalid0=%0b rvalid1=%0b expected none",
                        req0_rvalid, req1_rvalid);
            end else begin
               int          p;
               logic [31:0] d;
               p = exp_port_q.pop_front();
               d = exp_data_q.pop_front();
               chk("rvalid_port", req1_rvalid ? 32'd1 : 32'd0, 32'(p));
               chk("rdata", req1_rvalid ? req1_rdata : req0_rdata, d);
            end
         end
         if ((!req0_rvalid && req0_rdata != 0) || (!req1_rvalid && req1_rdata != 0)) begin
            checks++;
            errors++;
            $display("FAIL idle_rdata: got %h/%h expected 0", req0_rdata, req1_rdata);
         end
      end
   end

   task automatic chk_all_zero(input string tag);
      chk({tag, "_ready0"}, 32'(req0_ready), 32'd0);
      chk({tag, "_ready1"}, 32'(req1_ready), 32'd0);
      chk({tag, "_rvalid"}, 32'({req1_rvalid, req0_rvalid}), 32'd0);
      chk({tag, "_rdata0"}, req0_rdata, 32'd0);
      chk({tag, "_rdata1"}, req1_rdata, 32'd0);
      chk({tag, "_mem_we"}, 32'(mem_we), 32'd0);
      chk({tag, "_mem_addr"}, mem_addr, 32'd0);
      chk({tag, "_mem_wdata"}, mem_wdata, 32'd0);
   endtask

   initial begin
      int exp_grants[4] = '{0, 1, 0, 1};

      // Reset state, with a request pending to show ready is suppressed.
      req0_valid = 1'b1;
      repeat (3) @(negedge clk);
      chk_all_zero("reset");
      req0_valid = 1'b0;
      rst_n = 1'b1;

      // Reset mid-ACCESS drops the write.
      @(negedge clk);
      set_req(0, 1'b1, 1'b1, 32'd7, 32'h0000_1234);
      #1 chk("t1_ready0", 32'(req0_ready), 32'd1);
      @(posedge clk);
      #1 set_req(0, 1'b0, 1'b0, 32'd0, 32'd0);
      chk("t1_access_we", 32'(mem_we), 32'd1);
      #2 rst_n = 1'b0;
      #1 chk_all_zero("t1_async");
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      chk("t1_mem7_unchanged", mem[7], 32'd0);

      // Both ports continuously valid from reset: grants alternate starting at port 0.
      grant_log.delete();
      fork
         begin
            req(0, 1'b1, 32'd10, 32'hA0A0_A0A0, 32'd0);
            req(0, 1'b1, 32'd12, 32'hC0C0_C0C0, 32'd0);
         end
         begin
            req(1, 1'b1, 32'd11, 32'hB1B1_B1B1, 32'd0);
            req(1, 1'b0, 32'd10, 32'd0, 32'hA0A0_A0A0);
         end
      join
      drain();
      chk("t3_grant_count", 32'(grant_log.size()), 32'd4);
      for (int i = 0; i < 4 && i < grant_log.size(); i++)
         chk("t3_grant_order", 32'(grant_log[i]), 32'(exp_grants[i]));
      chk("t3_mem11", mem[11], 32'hB1B1_B1B1);

      // Write/read latency on port 0.
      req(0, 1'b1, 32'd5, 32'hDEAD_BEEF, 32'd0);
      chk("t2_we_t1", 32'(mem_we), 32'd1);
      chk("t2_addr_t1", mem_addr, 32'd5);
      chk("t2_wdata_t1", mem_wdata, 32'hDEAD_BEEF);
      chk("t2_rvalid_t1", 32'(req0_rvalid), 32'd0);
      @(posedge clk);
      #1 chk("t2_we_t2", 32'(mem_we), 32'd0);
      chk("t2_rvalid_t2", 32'(req0_rvalid), 32'd1);
      chk("t2_ready_resp", 32'(req0_ready), 32'd0);
      req(0, 1'b0, 32'd5, 32'd0, 32'hDEAD_BEEF);
      chk("t2_read_we", 32'(mem_we), 32'd0);
      drain();

      // Out-of-range accesses on port 1.
      req(1, 1'b0, 32'd64, 32'd0, 32'd0);
      req(1, 1'b1, 32'd100, 32'h7777_7777, 32'd0);
      chk("t4_oob_we", 32'(mem_we), 32'd0);
      chk("t4_oob_addr", mem_addr, 32'd100);
      drain();

      // Port 0 withdraws while port 1 owns the memory.
      req(1, 1'b0, 32'd5, 32'd0, 32'hDEAD_BEEF);
      set_req(0, 1'b1, 1'b1, 32'd20, 32'h5555_5555);
      @(negedge clk);
      #1 chk("t5_ready0_busy", 32'(req0_ready), 32'd0);
      set_req(0, 1'b0, 1'b1, 32'd20, 32'h5555_5555);
      repeat (6) @(negedge clk);
      chk("t5_mem20_untouched", mem[20], 32'd0);
      drain();

      // Fields change after the handshake; memory sees latched values.
      req(0, 1'b1, 32'd30, 32'h1234_5678, 32'd0);
      chk("t6_addr", mem_addr, 32'd30);
      chk("t6_wdata", mem_wdata, 32'h1234_5678);
      drain();
      chk("t6_mem30", mem[30], 32'h1234_5678);
      req(0, 1'b0, 32'd30, 32'd0, 32'h1234_5678);
      drain();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no completion expected finish before 200000");
      $fatal(1, "watchdog");
   end

endmodule
